// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and the loader state encoding for the
//                instruction-memory download path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Instruction-memory byte-address width (fetch path uses 8-bit addresses)
  localparam int ADDR_W = 8;

  // Frame start byte
  localparam logic [7:0] SYNC = 8'hA5;

  // Loader frame states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_LEN  = 3'd1,
    GET_ADDR = 3'd2,
    DATA     = 3'd3,
    GET_CSUM = 3'd4
  } state_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Writer side of the instruction memory. Receives a framed
//                byte stream (SYNC, LEN, ADDR, payload, CSUM) over a
//                valid/ready handshake, writes payload bytes into the
//                byte-addressed instruction memory and holds the core until
//                a frame passes its checksum.
//  Ports       : clk, rst            clock, async active-high reset
//                in_data/in_valid/in_ready   download stream handshake
//                mem_ready/mem_we/mem_addr/mem_wdata  memory write port
//                core_hold          stall PC/fetch (registered)
//                busy               frame in progress
//                load_done          one-cycle pulse on good checksum
//                load_err           sticky bad-checksum flag
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
  import cpu_pkg::*;
#(
  parameter int         ADDR_W = cpu_pkg::ADDR_W,
  parameter logic [7:0] SYNC   = cpu_pkg::SYNC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  state_t            r_state;
  state_t            w_state_next;
  logic [8:0]        r_cnt;      // payload bytes remaining (1..256)
  logic [ADDR_W-1:0] r_addr;     // next write address
  logic [7:0]        r_sum;      // running ADDR + payload sum
  logic              w_xfer;
  logic [7:0]        w_sum_chk;

  // Only the payload phase is throttled by the memory; header and checksum
  // bytes are always accepted.
  assign in_ready  = (r_state == DATA) ? mem_ready : 1'b1;
  assign w_xfer    = in_valid && in_ready;
  assign mem_addr  = r_addr;
  assign mem_wdata = in_data;
  assign busy      = (r_state != IDLE);
  assign w_sum_chk = r_sum + in_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and write strobe
  always_comb begin
    w_state_next = r_state;
    mem_we       = 1'b0;
    case (r_state)
      IDLE: begin
        // Non-SYNC bytes are accepted and dropped
        if (w_xfer && (in_data == SYNC)) w_state_next = GET_LEN;
      end
      GET_LEN: begin
        if (w_xfer) w_state_next = GET_ADDR;
      end
      GET_ADDR: begin
        if (w_xfer) w_state_next = DATA;
      end
      DATA: begin
        if (w_xfer) begin
          mem_we = 1'b1;
          if (r_cnt == 9'd1) w_state_next = GET_CSUM;
        end
      end
      GET_CSUM: begin
        if (w_xfer) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counters, checksum and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 9'd0;
      r_addr    <= '0;
      r_sum     <= 8'd0;
      core_hold <= 1'b1;   // never run an unloaded image
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (w_xfer) begin
        case (r_state)
          IDLE: begin
            if (in_data == SYNC) begin
              core_hold <= 1'b1;
              load_err  <= 1'b0;
            end
          end
          GET_LEN: begin
            // LEN of zero encodes a full 256-byte payload
            r_cnt <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          end
          GET_ADDR: begin
            r_addr <= ADDR_W'(in_data);
            r_sum  <= in_data;
          end
          DATA: begin
            r_addr <= r_addr + ADDR_W'(1);
            r_sum  <= w_sum_chk;
            r_cnt  <= r_cnt - 9'd1;
          end
          GET_CSUM: begin
            if (w_sum_chk == 8'd0) begin
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              load_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule : imem_loader

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       core_hold;
  logic       busy;
  logic       load_done;
  logic       load_err;

  logic tog    = 1'b0;
  logic tog_en = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  int wr_cnt   = 0;
  int done_cnt = 0;
  int bad_we   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) tog <= ~tog;
  assign mem_ready = tog_en ? tog : 1'b1;

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  // Memory model and event counters
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      if (!(in_valid && in_ready)) bad_we <= bad_we + 1;
    end
    if (load_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte and wait (bounded) for it to be accepted.
  // Returns just after the accepting rising edge.
  task automatic put(input logic [7:0] b);
    int  n;
    bit  done;
    in_data  = b;
    in_valid = 1'b1;
    n        = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else if (n > 20) begin
        n_cmp++;
        n_err++;
        $error("FAIL put_timeout: observed no transfer expected transfer of %0h", b);
        done = 1'b1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int wr0;
    int dn0;
    int k;
    #2000000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr0;
    int dn0;
    int k;
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // ---------------- reset ----------------
    #3;
    check("rst_core_hold", core_hold, 1);
    check("rst_in_ready",  in_ready,  1);
    check("rst_mem_we",    mem_we,    0);
    check("rst_busy",      busy,      0);
    check("rst_load_err",  load_err,  0);
    check("rst_load_done", load_done, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    check("post_rst_core_hold", core_hold, 1);
    check("post_rst_busy",      busy,      0);

    // ---------------- garbage before SYNC ----------------
    wr0 = wr_cnt;
    put(8'h00);
    put(8'hFF);
    check("garbage_busy", busy, 0);
    check("garbage_writes", wr_cnt - wr0, 0);

    // ---------------- good frame ----------------
    wr0 = wr_cnt; dn0 = done_cnt;
    put(8'hA5);
    check("a_sync_busy", busy, 1);
    check("a_sync_hold", core_hold, 1);
    put(8'h04); put(8'h10);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    put(8'h46);
    check("a_load_done", load_done, 1);
    check("a_core_hold", core_hold, 0);
    check("a_busy",      busy,      0);
    check("a_load_err",  load_err,  0);
    idle(1);
    check("a_done_pulse", load_done, 0);
    check("a_done_cnt", done_cnt - dn0, 1);
    check("a_writes", wr_cnt - wr0, 4);
    check("a_mem10", mem[8'h10], 8'h11);
    check("a_mem11", mem[8'h11], 8'h22);
    check("a_mem12", mem[8'h12], 8'h33);
    check("a_mem13", mem[8'h13], 8'h44);

    // ---------------- bad checksum ----------------
    wr0 = wr_cnt; dn0 = done_cnt;
    put(8'hA5);
    check("b_sync_hold", core_hold, 1);
    put(8'h04); put(8'h10);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    put(8'h47);
    idle(1);
    check("b_load_err",  load_err,  1);
    check("b_core_hold", core_hold, 1);
    check("b_busy",      busy,      0);
    check("b_writes", wr_cnt - wr0, 4);
    check("b_done_cnt", done_cnt - dn0, 0);

    // ---------------- recovery frame: 20 <- AA,55 csum E1 ----------------
    wr0 = wr_cnt; dn0 = done_cnt;
    put(8'hA5);
    check("c_err_cleared", load_err, 0);
    put(8'h02); put(8'h20);
    put(8'hAA); put(8'h55);
    put(8'hE1);
    check("c_load_done", load_done, 1);
    check("c_core_hold", core_hold, 0);
    idle(1);
    check("c_done_cnt", done_cnt - dn0, 1);
    check("c_mem20", mem[8'h20], 8'hAA);
    check("c_mem21", mem[8'h21], 8'h55);
    check("c_load_err", load_err, 0);

    // ---------------- throttled memory, address wrap ----------------
    wr0 = wr_cnt; dn0 = done_cnt;
    tog_en = 1'b1;
    put(8'hA5); put(8'h03); put(8'hFE);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("d_ready_mirror", in_ready, mem_ready);
    end
    @(posedge clk); #1;
    put(8'h01); put(8'h02); put(8'h03);
    k = 0;
    @(negedge clk);
    while (mem_ready && k < 3) begin
      @(negedge clk);
      k++;
    end
    check("d_csum_mem_ready_low", mem_ready, 0);
    check("d_csum_ready", in_ready, 1);
    @(posedge clk); #1;
    put(8'hFC);
    tog_en = 1'b0;
    check("d_load_done", load_done, 1);
    idle(1);
    check("d_writes", wr_cnt - wr0, 3);
    check("d_memFE", mem[8'hFE], 8'h01);
    check("d_memFF", mem[8'hFF], 8'h02);
    check("d_mem00", mem[8'h00], 8'h03);

    // ---------------- 256-byte frame: data = i+3, csum 0x80 ----------------
    wr0 = wr_cnt; dn0 = done_cnt;
    put(8'hA5); put(8'h00); put(8'h00);
    for (int i = 0; i < 256; i++) put(8'(i + 3));
    check("e_busy_before_csum", busy, 1);
    put(8'h80);
    check("e_load_done", load_done, 1);
    idle(1);
    check("e_writes", wr_cnt - wr0, 256);
    check("e_done_cnt", done_cnt - dn0, 1);
    check("e_mem00", mem[8'h00], 8'h03);
    check("e_mem7F", mem[8'h7F], 8'h82);
    check("e_memFF", mem[8'hFF], 8'h02);

    // ---------------- reset mid-DATA, then minimum frame ----------------
    wr0 = wr_cnt; dn0 = done_cnt;
    put(8'hA5); put(8'h04); put(8'h40);
    put(8'h01); put(8'h02);
    check("f_busy_mid", busy, 1);
    rst = 1'b1;
    #1;
    check("f_rst_busy",      busy,      0);
    check("f_rst_core_hold", core_hold, 1);
    check("f_rst_in_ready",  in_ready,  1);
    check("f_rst_mem_we",    mem_we,    0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("f_partial_writes", wr_cnt - wr0, 2);
    check("f_mem40_kept", mem[8'h40], 8'h01);
    put(8'hA5); put(8'h01); put(8'h50); put(8'h77); put(8'h39);
    check("f_load_done", load_done, 1);
    check("f_core_hold", core_hold, 0);
    idle(1);
    check("f_mem50", mem[8'h50], 8'h77);
    check("f_done_cnt", done_cnt - dn0, 1);

    check("no_spurious_we", bad_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_imem_loader

`default_nettype wire
